vocoder_mix_engine: RTL and testbench
=====================================

VOCODER_MIX_ENGINE -- requirements
Module: vocoder_mix_engine

Interface
REQ-001 Parameter N_CH, default 15: number of vocoder bands.
REQ-002 Parameter DW, default 16: signed sample width of all audio ports.
REQ-003 Parameter SHIFT, default 15: arithmetic right shift applied to the accumulated band sum.
REQ-004 Parameter GAIN_W, default 8: master gain width, unsigned Q(GAIN_W-4).4; 8'h10 = unity.
REQ-005 clk  in  1  single clock for all logic (MIC_CLK domain).
REQ-006 rst  in  1  reset, asynchronous assert, active-low; synchronous deassert.
REQ-007 env_in  in  N_CH x DW signed  envelope vector; latched on env_valid.
REQ-008 env_valid  in  1  one-cycle pulse; latches env_in and triggers a vocoded frame.
REQ-009 carrier_in  in  N_CH x DW signed  carrier vector; latched on car_valid.
REQ-010 car_valid  in  1  one-cycle pulse; latches carrier_in; never starts a frame.
REQ-011 dry_in  in  DW signed  unprocessed PCM sample.
REQ-012 dry_valid  in  1  one-cycle pulse; triggers a frame in modes 0 and 1.
REQ-013 mode  in  2  0 mute, 1 dry, 2 vocoded (all bands), 3 single band.
REQ-014 band_sel  in  clog2(N_CH)  band index used in mode 3; values >= N_CH select no band.
REQ-015 gain  in  GAIN_W  master gain.
REQ-016 clr_flags  in  1  clears overrun when high.
REQ-017 mix_out  out  DW signed  mixed sample; holds until the next mix_valid.
REQ-018 mix_valid  out  1  one-cycle pulse marking a new mix_out.
REQ-019 busy  out  1  high whenever FSM is not IDLE.
REQ-020 sat_flag  out  1  high with mix_valid when that sample was clamped; low otherwise.
REQ-021 overrun  out  1  sticky; set when a trigger arrives while busy.

Function
REQ-022 FSM states: IDLE, ACCUM, SCALE, OUT.
REQ-023 Mode, band_sel and gain are sampled at frame start; changes mid-frame do not affect that frame.
REQ-024 IDLE, mode 2/3, env_valid: latch env_in, clear acc, index=0, -> ACCUM; dry_valid is ignored in these modes.
REQ-025 IDLE, mode 0/1, dry_valid: acc = sign-extended dry_in <<< SHIFT (mode 1) or 0 (mode 0), -> SCALE; env_valid is ignored in these modes.
REQ-026 ACCUM: one signed DW x DW product per cycle, acc += env[index]*car[index]; in mode 3 only index == band_sel contributes, others add 0; after index N_CH-1 -> SCALE; always N_CH cycles.
REQ-027 acc width 2*DW + clog2(N_CH) + 1; no internal overflow is possible.
REQ-028 SCALE: s = (acc >>> SHIFT) * gain, then >>> 4; floor rounding (arithmetic shift); -> OUT.
REQ-029 OUT: mix_out = s clamped to [-2^(DW-1), 2^(DW-1)-1]; mix_valid=1; sat_flag=1 if clamped; -> IDLE.
REQ-030 Latency, trigger at cycle t: vocoded mix_valid at t+N_CH+2; dry/mute mix_valid at t+2.
REQ-031 Back-to-back frames: a trigger in the cycle after OUT (FSM in IDLE) is accepted.
REQ-032 Carrier latch is updated on every car_valid independently of FSM state; a frame uses the register contents each cycle it reads them.
REQ-033 Overrun: a qualifying trigger while busy is dropped and sets overrun; the frame in progress is unaffected.
REQ-034 Simultaneous clr_flags and overrun event: set wins.
REQ-035 Reset mid-frame aborts immediately; no mix_valid is emitted for the aborted frame.

Reset
REQ-036 While rst=0: FSM=IDLE; acc, index, env and carrier registers = 0; mix_out=0; mix_valid=0; busy=0; sat_flag=0; overrun=0.
REQ-037 The first trigger is honoured on the first clk edge after rst deasserts.

Verification
REQ-038 N_CH=4, mode 2, gain 8'h10, carrier all 16384, env all 8192, env_valid at t -> mix_out=16384 at t+6, sat_flag=0, busy high t+1..t+5.
REQ-039 Mode 3, band_sel=2, env={0,0,32767,0}, carrier={0,0,-32768,0}, gain 8'h10 -> mix_out=-32767, sat_flag=0; band_sel=5 -> mix_out=0.
REQ-040 Mode 1, dry_in=20000, gain 8'h20 -> mix_out=32767, sat_flag=1 at t+2; dry_in=-20000 -> -32768, sat_flag=1.
REQ-041 Mode 2, second env_valid 3 cycles after the first -> one mix_valid only, overrun=1; clr_flags pulse -> overrun=0.
REQ-042 rst pulsed low at t+2 of a vocoded frame -> no mix_valid; all outputs 0; next env_valid completes normally.
REQ-043 Mode switched 2->1 during ACCUM -> frame completes as vocoded; a subsequent dry_valid produces a dry sample.

Source files
------------

// File: rtl/vocoder_mix_engine.sv
// -----------------------------------------------------------------------------
// vocoder_mix_engine
//
// Mixes one output sample per frame from either a bank of vocoder bands
// (sum of envelope x carrier products) or a dry PCM sample, applies a master
// gain and saturates the result to the audio sample width.
//
// Frame flow: IDLE -> ACCUM (N_CH cycles, vocoded frames only) -> SCALE -> OUT.
//   mode 0 : mute     (dry_valid starts a frame that outputs 0)
//   mode 1 : dry      (dry_valid starts a frame that outputs dry_in * gain)
//   mode 2 : vocoded  (env_valid starts a frame summing all bands)
//   mode 3 : one band (env_valid starts a frame using band band_sel only)
//
// Ports
//   clk, rst          single clock; asynchronous active-low reset
//   env_in/env_valid  envelope vector, captured when a vocoded frame starts
//   carrier_in/car_valid  carrier vector, captured on every car_valid
//   dry_in/dry_valid  dry PCM sample and its frame trigger
//   mode, band_sel, gain  frame configuration, captured at frame start
//   clr_flags         clears the sticky overrun flag
//   mix_out/mix_valid mixed sample (held) and its one-cycle strobe
//   busy              frame in progress
//   sat_flag          strobed sample was clamped
//   overrun           sticky: a trigger arrived while busy and was dropped
// -----------------------------------------------------------------------------
module vocoder_mix_engine #(
  parameter int N_CH   = 15,
  parameter int DW     = 16,
  parameter int SHIFT  = 15,
  parameter int GAIN_W = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_CH-1:0][DW-1:0]                  env_in,
  input  logic                                     env_valid,
  input  logic [N_CH-1:0][DW-1:0]                  carrier_in,
  input  logic                                     car_valid,
  input  logic signed [DW-1:0]                     dry_in,
  input  logic                                     dry_valid,
  input  logic [1:0]                               mode,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] band_sel,
  input  logic [GAIN_W-1:0]                        gain,
  input  logic                                     clr_flags,
  output logic signed [DW-1:0]                     mix_out,
  output logic                                     mix_valid,
  output logic                                     busy,
  output logic                                     sat_flag,
  output logic                                     overrun
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  // Sum of N_CH full-scale DW x DW products cannot overflow this width.
  localparam int AW = 2 * DW + $clog2(N_CH) + 1;
  localparam int PW = AW + GAIN_W + 1;

  localparam logic signed [PW-1:0] MAX_V = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [N_CH-1:0][DW-1:0] env_q;
  logic [N_CH-1:0][DW-1:0] car_q;
  logic signed [AW-1:0]    acc;
  logic [IW-1:0]           index;
  logic                    single_q;   // frame runs in single-band mode
  logic [IW-1:0]           band_q;
  logic [GAIN_W-1:0]       gain_q;
  logic                    sat_q;

  // Mode decides which strobe is a frame trigger; the other one is ignored.
  logic trig_voc, trig_dry, trig_any, last_idx;
  assign trig_voc = mode[1] & env_valid;
  assign trig_dry = ~mode[1] & dry_valid;
  assign trig_any = trig_voc | trig_dry;
  assign last_idx = (index == IW'(N_CH - 1));

  // ---------------------------------------------------------------------------
  // Datapath arithmetic
  // ---------------------------------------------------------------------------
  logic signed [2*DW-1:0] env_x, car_x, prod;
  logic signed [AW-1:0]   term, dry_ext, acc_sh;
  logic signed [PW-1:0]   acc_x, gain_x, prod_g, s_val;
  logic signed [DW-1:0]   clamped;
  logic                   sat_d;

  assign env_x   = (2*DW)'($signed(env_q[index]));
  assign car_x   = (2*DW)'($signed(car_q[index]));
  assign prod    = env_x * car_x;
  // In single-band mode every other band still spends its cycle but adds 0,
  // keeping frame latency fixed. band_sel >= N_CH can never equal index.
  assign term    = (!single_q || (index == band_q)) ? AW'(prod) : '0;
  assign dry_ext = AW'(dry_in);

  // Arithmetic shifts give floor rounding for negative values.
  assign acc_sh  = acc >>> SHIFT;
  assign acc_x   = PW'(acc_sh);
  assign gain_x  = PW'(gain_q);
  assign prod_g  = acc_x * gain_x;
  assign s_val   = prod_g >>> 4;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    clamped = s_val[DW-1:0];
    sat_d   = 1'b0;
    if (s_val > MAX_V) begin
      clamped = MAX_V[DW-1:0];
      sat_d   = 1'b1;
    end else if (s_val < MIN_V) begin
      clamped = MIN_V[DW-1:0];
      sat_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig_voc)      state_d = S_ACCUM;
        else if (trig_dry) state_d = S_SCALE;
      end
      S_ACCUM: if (last_idx) state_d = S_SCALE;
      S_SCALE: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the envelope and carrier banks are cleared by reset on purpose: a
  // frame started right after reset must read zeros, not stale or X data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env_q    <= '0;
      car_q    <= '0;
      acc      <= '0;
      index    <= '0;
      single_q <= 1'b0;
      band_q   <= '0;
      gain_q   <= '0;
      mix_out  <= '0;
      sat_q    <= 1'b0;
    end else begin
      // The carrier bank tracks car_valid at all times; an in-flight frame
      // sees whatever is in the register on the cycle it reads a band.
      if (car_valid) car_q <= carrier_in;

      unique case (state_q)
        S_IDLE: begin
          if (trig_voc) begin
            env_q    <= env_in;
            acc      <= '0;
            index    <= '0;
            single_q <= mode[0];
            band_q   <= band_sel;
            gain_q   <= gain;
          end else if (trig_dry) begin
            acc      <= mode[0] ? (dry_ext <<< SHIFT) : '0;
            single_q <= 1'b0;
            band_q   <= band_sel;
            gain_q   <= gain;
          end
        end
        S_ACCUM: begin
          acc   <= acc + term;
          index <= index + IW'(1);
        end
        S_SCALE: begin
          mix_out <= clamped;
          sat_q   <= sat_d;
        end
        default: ;
      endcase
    end
  end

  // Dropped triggers set overrun; a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               overrun <= 1'b0;
    else if (trig_any && state_q != S_IDLE) overrun <= 1'b1;
    else if (clr_flags)                     overrun <= 1'b0;
  end

  assign busy      = (state_q != S_IDLE);
  assign mix_valid = (state_q == S_OUT);
  assign sat_flag  = mix_valid & sat_q;

endmodule

// File: tb/tb_vocoder_mix_engine.sv
// -----------------------------------------------------------------------------
// tb_vocoder_mix_engine
//
// Directed bench for vocoder_mix_engine. dut_a uses 4 bands (2-bit band_sel);
// dut_b uses 5 bands so that band_sel values >= N_CH are representable.
// Inputs change 1 time unit after the rising edge; outputs are read at that
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_vocoder_mix_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Shared stimulus
  logic signed [15:0] dry_in    = '0;
  logic               dry_valid = 1'b0;
  logic [7:0]         gain      = 8'h10;
  logic               clr_flags = 1'b0;

  // dut_a: 4 bands
  logic [3:0][15:0]   env_a       = '0;
  logic [3:0][15:0]   car_a       = '0;
  logic               env_valid_a = 1'b0;
  logic               car_valid_a = 1'b0;
  logic [1:0]         mode_a      = 2'd2;
  logic [1:0]         band_sel_a  = '0;
  logic signed [15:0] mix_out_a;
  logic               mix_valid_a, busy_a, sat_flag_a, overrun_a;

  // dut_b: 5 bands, never dry-triggered
  logic [4:0][15:0]   env_b       = '0;
  logic [4:0][15:0]   car_b       = '0;
  logic               env_valid_b = 1'b0;
  logic               car_valid_b = 1'b0;
  logic               dry_valid_b = 1'b0;
  logic [1:0]         mode_b      = 2'd3;
  logic [2:0]         band_sel_b  = '0;
  logic signed [15:0] mix_out_b;
  logic               mix_valid_b, busy_b, sat_flag_b, overrun_b;

  vocoder_mix_engine #(.N_CH(4), .DW(16), .SHIFT(15), .GAIN_W(8)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .env_in     (env_a),
    .env_valid  (env_valid_a),
    .carrier_in (car_a),
    .car_valid  (car_valid_a),
    .dry_in     (dry_in),
    .dry_valid  (dry_valid),
    .mode       (mode_a),
    .band_sel   (band_sel_a),
    .gain       (gain),
    .clr_flags  (clr_flags),
    .mix_out    (mix_out_a),
    .mix_valid  (mix_valid_a),
    .busy       (busy_a),
    .sat_flag   (sat_flag_a),
    .overrun    (overrun_a)
  );

  vocoder_mix_engine #(.N_CH(5), .DW(16), .SHIFT(15), .GAIN_W(8)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .env_in     (env_b),
    .env_valid  (env_valid_b),
    .carrier_in (car_b),
    .car_valid  (car_valid_b),
    .dry_in     (dry_in),
    .dry_valid  (dry_valid_b),
    .mode       (mode_b),
    .band_sel   (band_sel_b),
    .gain       (gain),
    .clr_flags  (clr_flags),
    .mix_out    (mix_out_b),
    .mix_valid  (mix_valid_b),
    .busy       (busy_b),
    .sat_flag   (sat_flag_b),
    .overrun    (overrun_b)
  );

  // Count every mix_valid strobe of dut_a.
  int mv_cnt_a = 0;
  always @(negedge clk) if (mix_valid_a === 1'b1) mv_cnt_a++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle t+1 of a frame; returns the cycle offset of mix_valid, or
  // -1 when it does not appear within the budget.
  task automatic wait_mv_a(input int budget, output int lat);
    lat = 1;
    while (mix_valid_a !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    if (mix_valid_a !== 1'b1) lat = -1;
  endtask

  task automatic wait_mv_b(input int budget, output int lat);
    lat = 1;
    while (mix_valid_b !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    if (mix_valid_b !== 1'b1) lat = -1;
  endtask

  task automatic load_car_a(input logic [3:0][15:0] v);
    car_a = v;
    car_valid_a = 1'b1;
    tick();
    car_valid_a = 1'b0;
  endtask

  // Pulses env_valid in cycle t; returns in cycle t+1.
  task automatic fire_env_a(input logic [3:0][15:0] v);
    env_a = v;
    env_valid_a = 1'b1;
    tick();
    env_valid_a = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int lat;
    mode_a = 2'd2;
    env_valid_a = 1'b1;   // held high through reset: must not start a frame
    car_valid_a = 1'b1;
    car_a = {4{16'd1000}};
    env_a = {4{16'd1000}};
    repeat (3) tick();
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    tests++; if (mix_valid_a !== 1'b0) begin fails++; $display("FAIL reset_mix_valid: got %b expected 0", mix_valid_a); end
    tests++; if (mix_out_a !== 16'sd0) begin fails++; $display("FAIL reset_mix_out: got %0d expected 0", mix_out_a); end
    tests++; if (sat_flag_a !== 1'b0 || overrun_a !== 1'b0) begin fails++; $display("FAIL reset_flags: got sat=%b ovr=%b expected 0 0", sat_flag_a, overrun_a); end
    tests++; if (busy_b !== 1'b0 || mix_valid_b !== 1'b0 || mix_out_b !== 16'sd0) begin fails++; $display("FAIL reset_dut_b: got busy=%b mv=%b out=%0d expected 0 0 0", busy_b, mix_valid_b, mix_out_b); end
    // Release with env_valid still high: the first edge must start a frame.
    car_valid_a = 1'b0;
    rst = 1'b1;
    tick();
    env_valid_a = 1'b0;
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL reset_first_trigger: got busy=%b expected 1", busy_a); end
    // Carrier register was held at zero through reset, so the result is 0.
    wait_mv_a(10, lat);
    tests++; if (lat !== 6 || mix_out_a !== 16'sd0) begin fails++; $display("FAIL reset_first_frame: got lat=%0d out=%0d expected lat=6 out=0", lat, mix_out_a); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_vocoded();
    int bad = 0;
    load_car_a({4{16'd16384}});
    mode_a = 2'd2;
    gain = 8'h10;
    fire_env_a({4{16'd8192}});
    for (int k = 1; k <= 5; k++) begin
      if (busy_a !== 1'b1 || mix_valid_a !== 1'b0) bad++;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL vocoded_busy: got %0d bad cycles in t+1..t+5 expected 0", bad); end
    tests++; if (mix_valid_a !== 1'b1) begin fails++; $display("FAIL vocoded_latency: got mix_valid=%b at t+6 expected 1", mix_valid_a); end
    tests++; if (mix_out_a !== 16'sd16384) begin fails++; $display("FAIL vocoded_out: got %0d expected 16384", mix_out_a); end
    tests++; if (sat_flag_a !== 1'b0) begin fails++; $display("FAIL vocoded_sat: got %b expected 0", sat_flag_a); end
    tick();
    tests++; if (busy_a !== 1'b0 || mix_valid_a !== 1'b0) begin fails++; $display("FAIL vocoded_end: got busy=%b mv=%b expected 0 0", busy_a, mix_valid_a); end
    tests++; if (mix_out_a !== 16'sd16384) begin fails++; $display("FAIL vocoded_hold: got %0d expected 16384", mix_out_a); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_band();
    int lat;
    load_car_a({16'd0, 16'h8000, 16'd0, 16'd0});
    mode_a = 2'd3;
    band_sel_a = 2'd2;
    gain = 8'h10;
    fire_env_a({16'd0, 16'd32767, 16'd0, 16'd0});
    band_sel_a = 2'd0;   // mid-frame change must be ignored
    wait_mv_a(10, lat);
    tests++; if (lat !== 6 || mix_out_a !== -16'sd32767) begin fails++; $display("FAIL single_band2: got lat=%0d out=%0d expected lat=6 out=-32767", lat, mix_out_a); end
    tests++; if (sat_flag_a !== 1'b0) begin fails++; $display("FAIL single_band2_sat: got %b expected 0", sat_flag_a); end
    tick();
    band_sel_a = 2'd1;   // only band 2 carries energy
    fire_env_a({16'd0, 16'd32767, 16'd0, 16'd0});
    wait_mv_a(10, lat);
    tests++; if (lat !== 6 || mix_out_a !== 16'sd0) begin fails++; $display("FAIL single_band1: got lat=%0d out=%0d expected lat=6 out=0", lat, mix_out_a); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_band_range();
    logic [2:0]         bands [4] = '{3'd4, 3'd5, 3'd7, 3'd0};
    logic [1:0]         modes [4] = '{2'd3, 2'd3, 2'd3, 2'd2};
    logic signed [15:0] exps  [4] = '{16'sd8192, 16'sd0, 16'sd0, 16'sd32767};
    logic               sats  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    car_b = {5{16'd16384}};
    car_valid_b = 1'b1;
    tick();
    car_valid_b = 1'b0;
    gain = 8'h10;
    for (int i = 0; i < 4; i++) begin
      mode_b = modes[i];
      band_sel_b = bands[i];
      env_b = {5{16'd16384}};
      env_valid_b = 1'b1;
      tick();
      env_valid_b = 1'b0;
      wait_mv_b(12, lat);
      tests++;
      if (lat !== 7 || mix_out_b !== exps[i] || sat_flag_b !== sats[i]) begin
        fails++;
        $display("FAIL band_range_%0d: got lat=%0d out=%0d sat=%b expected lat=7 out=%0d sat=%b",
                 i, lat, mix_out_b, sat_flag_b, exps[i], sats[i]);
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Back-to-back dry/mute frames, each triggered in the cycle after OUT.
  task automatic test_dry();
    logic [1:0]         modes [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic signed [15:0] drys  [5] = '{16'sd20000, -16'sd20000, -16'sd3, 16'sd5, 16'sd12345};
    logic [7:0]         gains [5] = '{8'h20, 8'h20, 8'h08, 8'h18, 8'h10};
    logic signed [15:0] exps  [5] = '{16'sd32767, -16'sd32768, -16'sd2, 16'sd7, 16'sd0};
    logic               sats  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    int cnt0;
    for (int i = 0; i < 5; i++) begin
      mode_a = modes[i];
      dry_in = drys[i];
      gain = gains[i];
      dry_valid = 1'b1;
      tick();
      dry_valid = 1'b0;
      wait_mv_a(5, lat);
      tests++;
      if (lat !== 2 || mix_out_a !== exps[i] || sat_flag_a !== sats[i]) begin
        fails++;
        $display("FAIL dry_%0d: got lat=%0d out=%0d sat=%b expected lat=2 out=%0d sat=%b",
                 i, lat, mix_out_a, sat_flag_a, exps[i], sats[i]);
      end
      tick();
    end
    tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL back_to_back_overrun: got %b expected 0", overrun_a); end
    // env_valid is not a trigger in dry mode.
    mode_a = 2'd1;
    cnt0 = mv_cnt_a;
    fire_env_a({4{16'd8192}});
    repeat (8) tick();
    tests++; if (mv_cnt_a !== cnt0 || busy_a !== 1'b0) begin fails++; $display("FAIL dry_ignores_env: got strobes=%0d busy=%b expected 0 0", mv_cnt_a - cnt0, busy_a); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overrun();
    int lat;
    int cnt0;
    load_car_a({4{16'd16384}});
    mode_a = 2'd2;
    gain = 8'h10;
    cnt0 = mv_cnt_a;
    fire_env_a({4{16'd8192}});   // t+1
    tick();                      // t+2
    tick();                      // t+3
    fire_env_a({4{16'd0}});      // dropped trigger at t+3, now t+4
    tests++; if (overrun_a !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", overrun_a); end
    wait_mv_a(10, lat);
    tests++; if (lat !== 3 || mix_out_a !== 16'sd16384) begin fails++; $display("FAIL overrun_frame_intact: got lat=%0d out=%0d expected lat=3 out=16384", lat, mix_out_a); end
    repeat (8) tick();
    tests++; if (mv_cnt_a - cnt0 !== 1) begin fails++; $display("FAIL overrun_single_strobe: got %0d strobes expected 1", mv_cnt_a - cnt0); end
    tests++; if (overrun_a !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun_a); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b expected 0", overrun_a); end
    // Set and clear in the same cycle: set wins.
    fire_env_a({4{16'd8192}});
    env_valid_a = 1'b1;
    clr_flags = 1'b1;
    tick();
    env_valid_a = 1'b0;
    clr_flags = 1'b0;
    tests++; if (overrun_a !== 1'b1) begin fails++; $display("FAIL overrun_set_wins: got %b expected 1", overrun_a); end
    wait_mv_a(10, lat);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Entered with overrun=1 and mix_out=16384 from the previous test.
  task automatic test_reset_midframe();
    int lat;
    int cnt0;
    mode_a = 2'd2;
    gain = 8'h10;
    fire_env_a({4{16'd8192}});   // t+1
    tick();                      // t+2
    rst = 1'b0;
    #1;
    tests++;
    if (busy_a !== 1'b0 || mix_valid_a !== 1'b0 || mix_out_a !== 16'sd0 ||
        sat_flag_a !== 1'b0 || overrun_a !== 1'b0) begin
      fails++;
      $display("FAIL midframe_reset_outputs: got busy=%b mv=%b out=%0d sat=%b ovr=%b expected all 0",
               busy_a, mix_valid_a, mix_out_a, sat_flag_a, overrun_a);
    end
    tick();
    tick();
    rst = 1'b1;
    cnt0 = mv_cnt_a;
    repeat (10) tick();
    tests++; if (mv_cnt_a !== cnt0) begin fails++; $display("FAIL midframe_reset_no_strobe: got %0d strobes expected 0", mv_cnt_a - cnt0); end
    load_car_a({4{16'd16384}});
    fire_env_a({4{16'd8192}});
    wait_mv_a(10, lat);
    tests++; if (lat !== 6 || mix_out_a !== 16'sd16384) begin fails++; $display("FAIL midframe_reset_recover: got lat=%0d out=%0d expected lat=6 out=16384", lat, mix_out_a); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mode_switch();
    int lat;
    mode_a = 2'd2;
    gain = 8'h10;
    fire_env_a({4{16'd8192}});
    mode_a = 2'd1;               // mid-frame: mode and gain must not apply
    gain = 8'h20;
    wait_mv_a(10, lat);
    tests++; if (lat !== 6 || mix_out_a !== 16'sd16384 || sat_flag_a !== 1'b0) begin fails++; $display("FAIL mode_switch_vocoded: got lat=%0d out=%0d sat=%b expected lat=6 out=16384 sat=0", lat, mix_out_a, sat_flag_a); end
    tick();
    dry_in = 16'sd1000;
    dry_valid = 1'b1;
    tick();
    dry_valid = 1'b0;
    wait_mv_a(5, lat);
    tests++; if (lat !== 2 || mix_out_a !== 16'sd2000) begin fails++; $display("FAIL mode_switch_dry: got lat=%0d out=%0d expected lat=2 out=2000", lat, mix_out_a); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_vocoded();
    test_single_band();
    test_band_range();
    test_dry();
    test_overrun();
    test_reset_midframe();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
